// File: rtl/alu_pkg.sv
// Shared widths, defaults, FSM encoding and the signature helper for the ALU sweep controller.
package alu_pkg;

  localparam int OPC_W       = 4;
  localparam int OPND_W      = 8;
  localparam int NUM_OPS_DEF = 16;
  localparam int ENTRY_W     = 16;
  localparam int BUF_DEPTH   = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_e;

  // Rotate the running signature left by one and fold in the new entry.
  function automatic logic [ENTRY_W-1:0] sig_next(input logic [ENTRY_W-1:0] sig,
                                                  input logic [ENTRY_W-1:0] entry);
    return {sig[ENTRY_W-2:0], sig[ENTRY_W-1]} ^ entry;
  endfunction

endpackage

// File: rtl/alu_result_buf.sv
// 16x16 result buffer: async-reset storage, synchronous write, registered read.
module alu_result_buf
  import alu_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [OPC_W-1:0]   wr_addr,
  input  logic [ENTRY_W-1:0] wr_data,
  input  logic [OPC_W-1:0]   rd_addr,
  output logic [ENTRY_W-1:0] rd_data
);

  logic [ENTRY_W-1:0] mem_q [BUF_DEPTH];
  logic [ENTRY_W-1:0] mem_d [BUF_DEPTH];
  logic [ENTRY_W-1:0] rd_data_q;
  logic [ENTRY_W-1:0] rd_data_d;

  // Next storage contents and read data; reads see pre-write contents.
  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[wr_addr] = wr_data;
    end else begin
      mem_d[wr_addr] = mem_q[wr_addr];
    end
    rd_data_d = mem_q[rd_addr];
  end

  // Storage and read-data registers, all cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_data_q <= '0;
    end else begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/alu_sweep_ctrl.sv
// Sweeps every opcode through an external ALU, buffers each {carry,result} and folds it into a signature.
module alu_sweep_ctrl
  import alu_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int NUM_OPS       = NUM_OPS_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [OPND_W-1:0]  A,
  input  logic [OPND_W-1:0]  B,
  output logic [OPND_W-1:0]  alu_a,
  output logic [OPND_W-1:0]  alu_b,
  output logic [OPC_W-1:0]   alu_opcode,
  input  logic [OPND_W-1:0]  alu_carry,
  input  logic [OPND_W-1:0]  alu_result,
  output logic               busy,
  output logic               done,
  output logic [ENTRY_W-1:0] signature,
  input  logic [OPC_W-1:0]   rd_addr,
  output logic [ENTRY_W-1:0] rd_data
);

  localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [OPC_W-1:0] LAST_OP     = OPC_W'(NUM_OPS - 1);

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [OPND_W-1:0]  a_q, a_d;
  logic [OPND_W-1:0]  b_q, b_d;
  logic [OPC_W-1:0]   op_q, op_d;
  logic [ENTRY_W-1:0] sig_q, sig_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               wr_en_s;
  logic [ENTRY_W-1:0] wr_data_s;

  // Next-state, datapath updates and buffer write strobe.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    sig_d     = sig_q;
    done_d    = 1'b0;
    wr_en_s   = 1'b0;
    wr_data_s = {alu_carry, alu_result};
    case (state_q)
      IDLE: begin
        if (abort) begin
          state_d = IDLE;
        end else if (start) begin
          a_d     = A;
          b_d     = B;
          op_d    = '0;
          sig_d   = '0;
          cnt_d   = 4'd0;
          state_d = SETTLE;
        end else begin
          state_d = IDLE;
        end
      end
      SETTLE: begin
        if (abort) begin
          cnt_d   = 4'd0;
          state_d = IDLE;
        end else if (cnt_q == SETTLE_LAST) begin
          cnt_d   = 4'd0;
          state_d = CAPTURE;
        end else begin
          cnt_d   = cnt_q + 4'd1;
        end
      end
      CAPTURE: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          wr_en_s = 1'b1;
          sig_d   = sig_next(sig_q, wr_data_s);
          if (op_q == LAST_OP) begin
            state_d = DONE;
          end else begin
            op_d    = op_q + 4'd1;
            state_d = SETTLE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        if (abort) begin
          done_d = 1'b0;
        end else begin
          done_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // Controller state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      sig_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      sig_q   <= sig_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  alu_result_buf u_buf (
    .clk     (clk),
    .rst     (rst),
    .we      (wr_en_s),
    .wr_addr (op_q),
    .wr_data (wr_data_s),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_opcode = op_q;
  assign signature  = sig_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_alu_sweep_ctrl.sv
// Directed bench for alu_sweep_ctrl with a stub ALU (result = A ^ opcode, carry = opcode).
module tb_alu_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start1, abort1, start3, abort3;
  logic [7:0]  A1, B1, A3, B3;
  logic [7:0]  alu_a1, alu_b1, alu_a3, alu_b3;
  logic [3:0]  op1, op3;
  logic [7:0]  carry1, result1, carry3, result3;
  logic        busy1, done1, busy3, done3;
  logic [15:0] sig1, sig3, rd_data1, rd_data3;
  logic [3:0]  rd_addr1, rd_addr3;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0]  addr;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs [6];

  always #5 clk = ~clk;

  assign result1 = alu_a1 ^ {4'h0, op1};
  assign carry1  = {4'h0, op1};
  assign result3 = alu_a3 ^ {4'h0, op3};
  assign carry3  = {4'h0, op3};

  alu_sweep_ctrl #(.SETTLE_CYCLES(1), .NUM_OPS(16)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort1), .A(A1), .B(B1),
    .alu_a(alu_a1), .alu_b(alu_b1), .alu_opcode(op1), .alu_carry(carry1),
    .alu_result(result1), .busy(busy1), .done(done1), .signature(sig1),
    .rd_addr(rd_addr1), .rd_data(rd_data1)
  );

  alu_sweep_ctrl #(.SETTLE_CYCLES(3), .NUM_OPS(16)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .abort(abort3), .A(A3), .B(B3),
    .alu_a(alu_a3), .alu_b(alu_b3), .alu_opcode(op3), .alu_carry(carry3),
    .alu_result(result3), .busy(busy3), .done(done3), .signature(sig3),
    .rd_addr(rd_addr3), .rd_data(rd_data3)
  );

  function automatic logic [15:0] entry(input logic [7:0] a, input int op);
    logic [3:0] o;
    o = 4'(op);
    return {4'h0, o, a ^ {4'h0, o}};
  endfunction

  function automatic logic [15:0] model_sig(input logic [7:0] a, input int n);
    logic [15:0] s;
    s = 16'h0000;
    for (int i = 0; i < n; i++) s = {s[14:0], s[15]} ^ entry(a, i);
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic read1(input logic [3:0] addr, output logic [15:0] data);
    rd_addr1 = addr;
    tick();
    data = rd_data1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    logic [15:0] d;
    logic        seen;
    int          edges;

    vecs[0] = '{4'd0,  16'h00AE};
    vecs[1] = '{4'd1,  16'h01AF};
    vecs[2] = '{4'd3,  16'h03AD};
    vecs[3] = '{4'd5,  16'h05AB};
    vecs[4] = '{4'd10, 16'h0AA4};
    vecs[5] = '{4'd15, 16'h0FA1};

    start1 = 1'b0; abort1 = 1'b0; A1 = 8'h00; B1 = 8'h00; rd_addr1 = 4'd0;
    start3 = 1'b0; abort3 = 1'b0; A3 = 8'h00; B3 = 8'h00; rd_addr3 = 4'd0;

    // Reset values
    rst = 1'b1;
    tick();
    check("rst_busy", busy1, 1'b0);
    check("rst_done", done1, 1'b0);
    check("rst_alu_a", alu_a1, 8'h00);
    check("rst_alu_b", alu_b1, 8'h00);
    check("rst_opcode", op1, 4'h0);
    check("rst_sig", sig1, 16'h0000);
    check("rst_rd_data", rd_data1, 16'h0000);
    rst = 1'b0;
    tick();

    // start and abort together in IDLE: abort wins
    A1 = 8'h11; start1 = 1'b1; abort1 = 1'b1;
    tick();
    start1 = 1'b0; abort1 = 1'b0;
    check("start_abort_busy", busy1, 1'b0);
    check("start_abort_alu_a", alu_a1, 8'h00);

    // Full sweep, SETTLE_CYCLES=1, with restart attempt and A change mid-sweep
    A1 = 8'hAE; B1 = 8'hE6; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    check("sw_busy_e0", busy1, 1'b1);
    check("sw_op_e0", op1, 4'h0);
    check("sw_a_e0", alu_a1, 8'hAE);
    check("sw_b_e0", alu_b1, 8'hE6);
    for (int k = 1; k <= 32; k++) begin
      if (k == 9) begin
        start1 = 1'b1; A1 = 8'h00; B1 = 8'h00;
      end
      tick();
      start1 = 1'b0;
      check($sformatf("sw_op_e%0d", k), op1, (k / 2 > 15) ? 15 : k / 2);
      check($sformatf("sw_busy_e%0d", k), busy1, 1'b1);
      check($sformatf("sw_done_e%0d", k), done1, 1'b0);
    end
    tick();
    check("sw_done_e33", done1, 1'b1);
    check("sw_busy_e33", busy1, 1'b0);
    tick();
    check("sw_done_e34", done1, 1'b0);
    check("sw_hold_op", op1, 4'hF);
    check("sw_hold_a", alu_a1, 8'hAE);
    check("sw_hold_b", alu_b1, 8'hE6);
    check("sw_sig", sig1, model_sig(8'hAE, 16));
    for (int i = 0; i < 6; i++) begin
      read1(vecs[i].addr, d);
      check($sformatf("vec_rd%0d", vecs[i].addr), d, vecs[i].exp);
    end
    for (int i = 0; i < 16; i++) begin
      read1(4'(i), d);
      check($sformatf("sw_rd%0d", i), d, entry(8'hAE, i));
    end

    // Abort at opcode 5 in SETTLE
    do_reset();
    A1 = 8'hAE; B1 = 8'hE6; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int k = 1; k <= 10; k++) tick();
    check("ab_op_before", op1, 4'h5);
    abort1 = 1'b1;
    tick();
    abort1 = 1'b0;
    check("ab_busy", busy1, 1'b0);
    check("ab_done", done1, 1'b0);
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (done1 || busy1) seen = 1'b1;
    end
    check("ab_no_done", seen, 1'b0);
    check("ab_sig", sig1, model_sig(8'hAE, 5));
    for (int i = 0; i < 16; i++) begin
      read1(4'(i), d);
      check($sformatf("ab_rd%0d", i), d, (i < 5) ? entry(8'hAE, i) : 16'h0000);
    end

    // Reset asserted at opcode 9, then a clean sweep
    A1 = 8'hAE; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int k = 1; k <= 18; k++) tick();
    check("rs_op_before", op1, 4'h9);
    rst = 1'b1;
    #1;
    check("rs_busy", busy1, 1'b0);
    check("rs_done", done1, 1'b0);
    check("rs_op", op1, 4'h0);
    check("rs_alu_a", alu_a1, 8'h00);
    check("rs_sig", sig1, 16'h0000);
    check("rs_rd_data", rd_data1, 16'h0000);
    tick();
    rst = 1'b0;
    tick();
    for (int i = 0; i < 16; i++) begin
      read1(4'(i), d);
      check($sformatf("rs_rd%0d", i), d, 16'h0000);
    end
    rd_addr1 = 4'd0;
    A1 = 8'h5C; B1 = 8'h33; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    tick();
    tick();
    check("rw_old_data", rd_data1, 16'h0000);
    tick();
    check("rw_new_data", rd_data1, entry(8'h5C, 0));
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      tick();
      if (done1) seen = 1'b1;
    end
    check("rs2_done_seen", seen, 1'b1);
    check("rs2_sig", sig1, model_sig(8'h5C, 16));
    for (int i = 0; i < 16; i++) begin
      read1(4'(i), d);
      check($sformatf("rs2_rd%0d", i), d, entry(8'h5C, i));
    end

    // SETTLE_CYCLES=3 instance: 4 cycles per opcode, done 65 edges after start
    A3 = 8'hAE; B3 = 8'hE6; start3 = 1'b1;
    tick();
    start3 = 1'b0;
    edges = 0;
    seen = 1'b0;
    for (int k = 1; k <= 64; k++) begin
      tick();
      check($sformatf("s3_op_e%0d", k), op3, (k / 4 > 15) ? 15 : k / 4);
      if (done3) seen = 1'b1;
    end
    check("s3_no_early_done", seen, 1'b0);
    tick();
    check("s3_done_e65", done3, 1'b1);
    check("s3_busy_e65", busy3, 1'b0);
    check("s3_sig", sig3, model_sig(8'hAE, 16));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
